// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requests onto one in-order memory port and routes responses back.
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin priority instead of fixed data-first.
module mem_port_arbiter #(
  parameter int unsigned OST_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  input  logic        flush,
  output logic        rsp_err
);

  localparam int unsigned PTR_W = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD_INST, ST_HOLD_DATA} state_t;

  state_t             state, state_nxt;
  logic               cur_owner;
  logic               cur_req;
  logic               arb_data;
  logic               fifo_full;
  logic               push, pop;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               owner_q   [OST_DEPTH];
  logic               discard_q [OST_DEPTH];

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_data_first;

  // Last winner drops to low priority.
  always_ff @(posedge clk) begin
    if (reset)     rr_data_first <= 1'b0;
    else if (push) rr_data_first <= (cur_owner == OWN_INST);
  end

  assign arb_data = data_req && (!inst_req || rr_data_first);
`else
  assign arb_data = data_req;
`endif

  assign fifo_full = (count == CNT_W'(OST_DEPTH));

  // Grant state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // A grant is held only while its request waits for mem_addr_ok; flush drops a waiting fetch.
  always_comb begin
    state_nxt = ST_IDLE;
    if (mem_req && !mem_addr_ok) begin
      if (cur_owner == OWN_DATA) state_nxt = ST_HOLD_DATA;
      else if (!flush)           state_nxt = ST_HOLD_INST;
    end
  end

  // Request path: owner select and mem_* field mux.
  always_comb begin
    cur_owner = OWN_INST;
    case (state)
      ST_HOLD_DATA: cur_owner = OWN_DATA;
      ST_HOLD_INST: cur_owner = OWN_INST;
      default:      cur_owner = arb_data ? OWN_DATA : OWN_INST;
    endcase
    cur_req      = (cur_owner == OWN_DATA) ? data_req : inst_req;
    mem_req      = !reset && !fifo_full && cur_req;
    mem_wr       = 1'b0;
    mem_wstrb    = 4'h0;
    mem_wdata    = 32'h0;
    mem_addr     = inst_addr;
    if (cur_owner == OWN_DATA) begin
      mem_wr    = data_wr;
      mem_wstrb = data_wstrb;
      mem_wdata = data_wdata;
      mem_addr  = data_addr;
    end
    inst_addr_ok = mem_req && mem_addr_ok && (cur_owner == OWN_INST);
    data_addr_ok = mem_req && mem_addr_ok && (cur_owner == OWN_DATA);
  end

  assign push = mem_req && mem_addr_ok;
  assign pop  = !reset && mem_data_ok && (count != '0);

  // Response path follows the owner FIFO head.
  assign inst_data_ok = pop && (owner_q[rd_ptr] == OWN_INST) && !discard_q[rd_ptr];
  assign data_data_ok = pop && (owner_q[rd_ptr] == OWN_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Owner FIFO; flush marks every fetch entry, including one written this cycle, as discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < OST_DEPTH; i++) begin
        owner_q[i]   <= OWN_INST;
        discard_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < OST_DEPTH; i++) begin
        if (flush && (owner_q[i] == OWN_INST)) discard_q[i] <= 1'b1;
      end
      if (push) begin
        owner_q[wr_ptr]   <= cur_owner;
        discard_q[wr_ptr] <= flush && (cur_owner == OWN_INST);
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Sticky flag for a response with nothing outstanding.
  always_ff @(posedge clk) begin
    if (reset)                              rsp_err <= 1'b0;
    else if (mem_data_ok && (count == '0)) rsp_err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration, grant hold, FIFO limit, flush and error flag.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic DATA_FIRST = 1'b0;
`else
  localparam logic DATA_FIRST = 1'b1;
`endif

  mem_port_arbiter #(.OST_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .flush(flush), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; checks happen at the following negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1c000000;
    data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'h0;
    data_addr = 32'h1c008000; data_wdata = 32'h12345678;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0;

    // Reset: everything quiet even with requests and a response present.
    next_cycle(); next_cycle();
    #4;
    check_eq("rst_mem_req", 32'(mem_req), 32'h0);
    check_eq("rst_addr_ok", {30'h0, inst_addr_ok, data_addr_ok}, 32'h0);
    check_eq("rst_data_ok", {30'h0, inst_data_ok, data_data_ok}, 32'h0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'h0);
    next_cycle();
    reset = 1'b0; mem_data_ok = 1'b0;

    // Simultaneous requests.
    #4;
    check_eq("arb1_addr", mem_addr, DATA_FIRST ? 32'h1c008000 : 32'h1c000000);
    check_eq("arb1_data_ok", 32'(data_addr_ok), 32'(DATA_FIRST));
    check_eq("arb1_inst_ok", 32'(inst_addr_ok), 32'(!DATA_FIRST));
    next_cycle();
    if (DATA_FIRST) data_req = 1'b0; else inst_req = 1'b0;
    #4;
    check_eq("arb2_addr", mem_addr, DATA_FIRST ? 32'h1c000000 : 32'h1c008000);
    check_eq("arb2_data_ok", 32'(data_addr_ok), 32'(!DATA_FIRST));
    check_eq("arb2_inst_ok", 32'(inst_addr_ok), 32'(DATA_FIRST));
    if (DATA_FIRST) begin
      check_eq("fetch_wr", {27'h0, mem_wr, mem_wstrb}, 32'h0);
      check_eq("fetch_wdata", mem_wdata, 32'h0);
    end
    next_cycle();
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h11111111;
    #4;
    check_eq("rsp1_data_ok", 32'(data_data_ok), 32'(DATA_FIRST));
    check_eq("rsp1_inst_ok", 32'(inst_data_ok), 32'(!DATA_FIRST));
    check_eq("rsp1_rdata", DATA_FIRST ? data_rdata : inst_rdata, 32'h11111111);
    next_cycle();
    mem_rdata = 32'h22222222;
    #4;
    check_eq("rsp2_data_ok", 32'(data_data_ok), 32'(!DATA_FIRST));
    check_eq("rsp2_inst_ok", 32'(inst_data_ok), 32'(DATA_FIRST));
    next_cycle();
    mem_data_ok = 1'b0;

    // Store transfer and its response.
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hf;
    data_addr = 32'h1c010000; data_wdata = 32'hdeadbeef; mem_addr_ok = 1'b1;
    #4;
    check_eq("st_fields", {27'h0, mem_req, mem_wr, mem_wstrb}, 32'h3f);
    check_eq("st_addr", mem_addr, 32'h1c010000);
    check_eq("st_wdata", mem_wdata, 32'hdeadbeef);
    check_eq("st_addr_ok", 32'(data_addr_ok), 32'h1);
    next_cycle();
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    #4;
    check_eq("st_data_ok", {30'h0, inst_data_ok, data_data_ok}, 32'h1);
    next_cycle();
    mem_data_ok = 1'b0;

    // Grant held while the port stalls and the other requester rises.
    inst_req = 1'b1; inst_addr = 32'h1c000100;
    #4;
    check_eq("hold0_req", 32'(mem_req), 32'h1);
    check_eq("hold0_addr", mem_addr, 32'h1c000100);
    next_cycle();
    data_req = 1'b1; data_addr = 32'h1c008100;
    for (int i = 1; i < 3; i++) begin
      #4;
      check_eq($sformatf("hold%0d_addr", i), mem_addr, 32'h1c000100);
      check_eq($sformatf("hold%0d_ok", i), {30'h0, inst_addr_ok, data_addr_ok}, 32'h0);
      next_cycle();
    end
    mem_addr_ok = 1'b1;
    #4;
    check_eq("hold_xfer_addr", mem_addr, 32'h1c000100);
    check_eq("hold_xfer_ok", {30'h0, inst_addr_ok, data_addr_ok}, 32'h2);
    next_cycle();
    inst_req = 1'b0;
    #4;
    check_eq("hold_next_addr", mem_addr, 32'h1c008100);
    check_eq("hold_next_ok", 32'(data_addr_ok), 32'h1);
    next_cycle();
    data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    #4;
    check_eq("hold_rsp1", {30'h0, inst_data_ok, data_data_ok}, 32'h2);
    next_cycle();
    #4;
    check_eq("hold_rsp2", {30'h0, inst_data_ok, data_data_ok}, 32'h1);
    next_cycle();
    mem_data_ok = 1'b0;

    // Flush drops a fetch still waiting for acceptance.
    inst_req = 1'b1; inst_addr = 32'h1c000200;
    next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0; inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h1c008200; mem_addr_ok = 1'b1;
    #4;
    check_eq("fl_pend_addr", mem_addr, 32'h1c008200);
    check_eq("fl_pend_ok", 32'(data_addr_ok), 32'h1);
    next_cycle();
    data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    #4;
    check_eq("fl_pend_rsp", {30'h0, inst_data_ok, data_data_ok}, 32'h1);
    next_cycle();
    mem_data_ok = 1'b0;

    // Flush discards an outstanding fetch response.
    inst_req = 1'b1; inst_addr = 32'h1c000004; mem_addr_ok = 1'b1;
    #4;
    check_eq("fl_out_ok", 32'(inst_addr_ok), 32'h1);
    next_cycle();
    inst_req = 1'b0; mem_addr_ok = 1'b0; flush = 1'b1;
    next_cycle();
    flush = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h02800000;
    #4;
    check_eq("fl_out_rsp", {30'h0, inst_data_ok, data_data_ok}, 32'h0);
    next_cycle();
    mem_data_ok = 1'b0;
    #4;
    check_eq("fl_out_err", 32'(rsp_err), 32'h0);
    next_cycle();

    // Outstanding limit: four accepted, fifth blocked until a response pops.
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_addr = 32'h1c000010 + 32'(4 * i);
      #4;
      check_eq($sformatf("full_acc%0d", i), 32'(inst_addr_ok), 32'h1);
      next_cycle();
    end
    inst_addr = 32'h1c000020; mem_data_ok = 1'b1;
    #4;
    check_eq("full_block_req", 32'(mem_req), 32'h0);
    check_eq("full_block_ok", 32'(inst_addr_ok), 32'h0);
    check_eq("full_pop", 32'(inst_data_ok), 32'h1);
    next_cycle();
    mem_data_ok = 1'b0;
    #4;
    check_eq("full_resume", {30'h0, mem_req, inst_addr_ok}, 32'h3);
    next_cycle();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #4;
      check_eq($sformatf("full_drain%0d", i), 32'(inst_data_ok), 32'h1);
      next_cycle();
    end

    // Response with nothing outstanding.
    #4;
    check_eq("err_rsp", {30'h0, inst_data_ok, data_data_ok}, 32'h0);
    next_cycle();
    mem_data_ok = 1'b0;
    #4;
    check_eq("err_set", 32'(rsp_err), 32'h1);
    next_cycle(); next_cycle();
    #4;
    check_eq("err_sticky", 32'(rsp_err), 32'h1);
    next_cycle();

    // Reset clears the flag and forgets outstanding requests.
    inst_req = 1'b1; inst_addr = 32'h1c000300; mem_addr_ok = 1'b1;
    next_cycle();
    inst_req = 1'b0; mem_addr_ok = 1'b0; reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #4;
    check_eq("rst2_err", 32'(rsp_err), 32'h0);
    next_cycle();
    mem_data_ok = 1'b1;
    #4;
    check_eq("rst2_rsp", 32'(inst_data_ok), 32'h0);
    next_cycle();
    mem_data_ok = 1'b0;
    #4;
    check_eq("rst2_err_set", 32'(rsp_err), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
